// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and default payload width.
package serial_rx_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shift register; bits enter at the MSB so the first bit received ends at bit 0.
module sipo_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (shift_en) begin
      if (DATA_W > 1) q_q <= {d, q_q[DATA_W-1:1]};
      else            q_q <= {DATA_W{d}};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W payload bits LSB first, optional even parity, stop bit.
// Define SERIAL_RX_PARITY_EN to add the parity bit and the parity_err output.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
`ifdef SERIAL_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              shift_en;
  logic [DATA_W-1:0] shift_q;
  logic              stop_ok;

  sipo_shift #(.DATA_W(DATA_W)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .d        (d),
    .q        (shift_q)
  );

`ifdef SERIAL_RX_PARITY_EN
  logic par_ok_q, par_ok_d;
  logic parity_err_q, parity_err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_ok_q     <= 1'b1;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
      par_ok_q     <= par_ok_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    shift_en    = 1'b0;
    stop_ok     = d;
`ifdef SERIAL_RX_PARITY_EN
    par_ok_d     = par_ok_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!d) state_d = DATA;
      end
      DATA: begin
        shift_en = 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        // Even parity: the parity bit makes the total count of ones even.
        par_ok_d = (d == ^shift_q);
        state_d  = STOP;
      end
`endif
      STOP: begin
        state_d     = IDLE;
        frame_err_d = !d;
`ifdef SERIAL_RX_PARITY_EN
        parity_err_d = !par_ok_q;
        stop_ok      = d && par_ok_q;
`endif
        if (stop_ok) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with a scoreboard of expected output pulses and their cycle.
module tb_serial_frame_rx;

  localparam int W = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         d = 1'b1;
  logic [W-1:0] data;
  logic         valid, frame_err, busy;
  logic         perr;

  serial_frame_rx #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err (perr),
`endif
    .busy       (busy)
  );

`ifndef SERIAL_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic         fe;
    logic         pe;
    logic [W-1:0] dat;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] model_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      model_data = '0;
    end else begin
      check("valid_fe_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (valid || frame_err || perr) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, valid, frame_err, perr}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("valid", {31'd0, valid}, {31'd0, e.v});
          check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
          check("parity_err", {31'd0, perr}, {31'd0, e.pe});
          if (e.v) model_data = e.dat;
          $display("frame: data=0x%02h valid=%0b frame_err=%0b parity_err=%0b at cycle %0d",
                   data, valid, frame_err, perr, cyc);
        end
      end
      check("data_hold", {24'd0, data}, {24'd0, model_data});
    end
  end

  task automatic send_frame(input logic [W-1:0] p, input logic stop, input logic pbad);
    exp_t e;
    @(negedge clk);
    e.v   = stop && !(pbad && PAR == 1);
    e.fe  = !stop;
    e.pe  = pbad && PAR == 1;
    e.dat = p;
    e.cyc = cyc + W + 2 + PAR;
    sb_q.push_back(e);
    d = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      d = p[i];
    end
    if (PAR == 1) begin
      @(negedge clk);
      d = (^p) ^ pbad;
    end
    @(negedge clk);
    d = stop;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d = 1'b1;
    end
  endtask

  initial begin
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_data", {24'd0, data}, 32'd0);
    #22 rst_n = 1'b1;

    // Line idles high: nothing may start.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      d = 1'b1;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_fe", {31'd0, frame_err}, 32'd0);
    end

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(3);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(3);
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h99, 1'b0, 1'b0);
    idle(4);
    check("busy_after_frames", {31'd0, busy}, 32'd0);

    // Abort mid-frame with reset after four payload bits.
    @(negedge clk);
    d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_data", {24'd0, data}, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    d = 1'b1;
    @(negedge clk);
    #3 rst_n = 1'b1;
    idle(12);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(4);

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b0);
    idle(2);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(2);
    send_frame(8'h7E, 1'b1, 1'b0);
    send_frame(8'h12, 1'b0, 1'b1);
    idle(2);
`endif

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(15);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

endmodule
